count_pwm_gen: RTL
==================

Name: count_pwm_gen

Overview:
- Downstream consumer of the 6-bit loadable up-counter output (Count).
- Turns the counter value into a PWM waveform with a programmable duty.
- A valid/ready handshake loads a new duty value into a shadow register. The shadow value becomes active only at counter wrap (63->0), so the output never glitches.
- Also produces a wrap strobe and an 8-bit wrap tally for timing software.

Parameters:
- CW, 6, counter width; wrap detected from all-ones to zero
- WW, 8, wrap tally width

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Count  in  CW  counter value from the upstream counter stage
- DutyData  in  CW  requested duty, in counter ticks high per period
- DutyValid  in  1  DutyData is valid this cycle
- DutyReady  out  1  shadow register empty; DutyData accepted when Valid&Ready
- PwmOut  out  1  registered PWM output
- WrapPulse  out  1  one-cycle strobe on detected wrap
- WrapCount  out  WW  number of wraps since reset, modulo 2^WW
- Discont  out  1  one-cycle strobe on count discontinuity (optional feature only)

Behaviour:
- Reset (Reset=0, async) sets:
  - PwmOut=0, WrapPulse=0, WrapCount=0, Discont=0, DutyReady=1
  - active duty=0, shadow=0, prev_count=0, state=IDLE
- Reset deassertion is sampled on the rising Clock edge.
- Reset mid-operation drops any pending shadow value; it does not commit it.
- prev_count registers Count every cycle.
- Wrap condition: prev_count==2^CW-1 and Count==0.
  - Any other jump to 0, e.g. from an upstream Load or its own reset, is not a wrap.
- FSM states: IDLE, RUN, PEND.
  - IDLE: no duty ever committed; PwmOut forced 0; DutyReady=1. On accept -> PEND.
  - PEND: shadow holds value; DutyReady=0. On wrap -> commit shadow to active, -> RUN.
  - RUN: DutyReady=1. On accept -> PEND.
  - Accept in RUN on the same edge as a wrap: the new value is not committed at that wrap. The current active duty is kept; go to PEND and commit at the next wrap.
- Commit and compare timing:
  - At the commit edge, the compare uses the newly committed duty, so the period starting at Count=0 fully uses the new value.
- PwmOut:
  - Registered: PwmOut <= (state_next!=IDLE) && (Count < duty_next).
  - Latency: one clock from Count.
  - Duty 0 -> constant low. Duty 63 -> high 63 of 64 ticks; 100% is not representable.
  - Compare is unsigned, CW bits.
- Counter stalls (Enable low upstream, Count constant):
  - PwmOut holds its level.
  - No wrap is detected.
  - A pending duty waits.
- WrapPulse:
  - High for exactly the cycle after the wrap edge (registered).
  - WrapCount increments on the same edge as WrapPulse asserts.
  - WrapCount rolls over from 255 to 0.
- DutyValid held with DutyReady low: the bench must keep the value stable. The block samples it only when DutyReady=1.

Optional Feature:
- Macro: PWM_DISC_RESYNC_EN.
- Defined:
  - Discontinuity = Count != prev_count and Count != prev_count+1 (mod 2^CW), excluding the wrap condition.
  - On a discontinuity, Discont pulses for one cycle (registered).
  - PwmOut is forced low until the next wrap; the period is resynchronised.
  - A pending commit still waits for a true wrap.
- Undefined:
  - No discontinuity logic.
  - Discont tied to 0.
  - PwmOut follows the compare rule immediately after any jump.

Test Plan:
1. Reset low at 2.5 ns, released mid-cycle -> all outputs 0, DutyReady=1. PwmOut stays 0 while Count runs 0..63 (IDLE).
2. Write DutyData=16 with Count=5 -> DutyReady drops next cycle. After Count 63->0, PwmOut is high for Count 0..15 and low for 16..63. WrapPulse=1 one cycle, WrapCount=1. DutyReady returns to 1.
3. In RUN with duty 16, write DutyData=40 on the same edge Count goes 63->0 -> that period still uses 16. The next period uses 40.
4. Upstream Load forces Count 20->60 (not a wrap) -> WrapPulse stays 0. With PWM_DISC_RESYNC_EN: Discont=1 one cycle and PwmOut=0 until the next 63->0. Without the macro: Discont=0 and PwmOut follows the compare.
5. Hold Count at 10 for 5 cycles with duty 32 -> PwmOut stays 1, no wrap, pending duty not committed.
6. Assert Reset while in PEND -> DutyReady=1, state IDLE, PwmOut=0. The shadow value is never applied at the following wrap.

Source files
------------

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running counter, with shadowed duty load,
// wrap strobe/tally and (with PWM_DISC_RESYNC_EN) count-discontinuity resynchronisation.
`timescale 1ns/1ps
module count_pwm_gen #(
   parameter int CW = 6,
   parameter int WW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [CW-1:0] count_i,
   input  logic [CW-1:0] duty_data_i,
   input  logic          duty_valid_i,
   output logic          duty_ready_o,
   output logic          pwm_o,
   output logic          wrap_pulse_o,
   output logic [WW-1:0] wrap_count_o,
   output logic          discont_o,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_e;

   localparam logic [CW-1:0] CNT_MAX = '1;

   state_e        state_q, state_d;
   logic [CW-1:0] shadow_q, shadow_d;
   logic [CW-1:0] active_q, active_d;
   logic [CW-1:0] prev_q;
   logic          pwm_q, pwm_d;
   logic          wrap_pulse_q;
   logic [WW-1:0] wrap_count_q;
   logic          wrap;
   logic          accept;

   // Handshake: a duty value transfers on any rising edge where duty_valid_i and
   // duty_ready_o are both high; ready is low only while a value waits in the shadow.
   assign wrap   = (prev_q == CNT_MAX) && (count_i == '0);
   assign accept = duty_valid_i && (state_q != PEND);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      case (state_q)
         IDLE, RUN: begin
            // An accept coinciding with a wrap is held for the following wrap.
            if (accept) begin
               state_d  = PEND;
               shadow_d = duty_data_i;
            end
         end
         PEND: begin
            if (wrap) begin
               state_d  = RUN;
               active_d = shadow_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef PWM_DISC_RESYNC_EN
   logic          resync_q, resync_d;
   logic          discont_q;
   logic          disc;
   logic [CW-1:0] prev_inc;

   assign prev_inc = prev_q + CW'(1);
   assign disc     = (count_i != prev_q) && (count_i != prev_inc) && !wrap;

   always_comb begin
      resync_d = resync_q;
      if (disc)      resync_d = 1'b1;
      else if (wrap) resync_d = 1'b0;
      pwm_d = (state_d != IDLE) && (count_i < active_d) && !resync_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resync_q  <= 1'b0;
         discont_q <= 1'b0;
      end else begin
         resync_q  <= resync_d;
         discont_q <= disc;
      end
   end

   assign discont_o = discont_q;
`else
   always_comb begin
      pwm_d = (state_d != IDLE) && (count_i < active_d);
   end

   assign discont_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         shadow_q     <= '0;
         active_q     <= '0;
         prev_q       <= '0;
         pwm_q        <= 1'b0;
         wrap_pulse_q <= 1'b0;
         wrap_count_q <= '0;
      end else begin
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         prev_q       <= count_i;
         pwm_q        <= pwm_d;
         wrap_pulse_q <= wrap;
         if (wrap) wrap_count_q <= wrap_count_q + WW'(1);
      end
   end

   assign duty_ready_o = (state_q != PEND);
   assign pwm_o        = pwm_q;
   assign wrap_pulse_o = wrap_pulse_q;
   assign wrap_count_o = wrap_count_q;
   assign state_o      = state_q;

endmodule
